// File: rtl/mem_dma_2rw_pkg.sv
// Shared types for the mem_dma_2rw block-transfer initiator.
//   mode_e  : command mode encoding carried on the 1-bit mode input
//   state_e : transfer sequencer states
package mem_dma_2rw_pkg;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_LAST,
    ST_WRF,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_dma_2rw_if.sv
// Two-port memory bus between the DMA initiator and a mem_2rw instance.
//   port 1 : re1/we1/addr1/wr_data1/be1 toward memory, rd_data1 back
//   port 2 : re2/we2/addr2/wr_data2/be2 toward memory, rd_data2 back
//   master : the initiator (drives enables, addresses, write data)
//   slave  : the memory (returns read data, one clock after the read enable)
interface mem_dma_2rw_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_BYTES = 8
);
  logic                    re1;
  logic                    we1;
  logic [ADDR_WIDTH-1:0]   addr1;
  logic [8*WORD_BYTES-1:0] wr_data1;
  logic [WORD_BYTES-1:0]   be1;
  logic [8*WORD_BYTES-1:0] rd_data1;

  logic                    re2;
  logic                    we2;
  logic [ADDR_WIDTH-1:0]   addr2;
  logic [8*WORD_BYTES-1:0] wr_data2;
  logic [WORD_BYTES-1:0]   be2;
  logic [8*WORD_BYTES-1:0] rd_data2;

  modport master (
    output re1, we1, addr1, wr_data1, be1,
    input  rd_data1,
    output re2, we2, addr2, wr_data2, be2,
    input  rd_data2
  );

  modport slave (
    input  re1, we1, addr1, wr_data1, be1,
    output rd_data1,
    input  re2, we2, addr2, wr_data2, be2,
    output rd_data2
  );
endinterface

// File: rtl/mem_dma_2rw.sv
// Block-transfer initiator for a dual-port mem_2rw. Port 1 only reads, port 2
// only writes. COPY moves len words src->dst at one word per clock; FILL
// writes fill_data to len consecutive words. Addresses wrap modulo 2^ADDR_WIDTH.
//   clk, rst              : clock (posedge) and asynchronous active-high reset
//   start, mode           : command strobe (IDLE only) and 0=COPY / 1=FILL
//   src_addr, dst_addr    : first source / destination word
//   len                   : word count 0..2^ADDR_WIDTH
//   fill_data, wr_be      : FILL pattern and byte enable for every write
//   busy, done            : transfer in progress / one-cycle completion pulse
//   mem                   : memory bus (master side)
module mem_dma_2rw
  import mem_dma_2rw_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [ADDR_WIDTH:0]     len,
  input  logic [8*WORD_BYTES-1:0] fill_data,
  input  logic [WORD_BYTES-1:0]   wr_be,
  output logic                    busy,
  output logic                    done,
  mem_dma_2rw_if.master           mem
);

  state_e                  state;
  logic [ADDR_WIDTH:0]     cnt;      // operations remaining after the current one
  logic [ADDR_WIDTH-1:0]   wr_ptr;   // next COPY destination address
  logic [WORD_BYTES-1:0]   be_q;
  logic                    re1_q;
  logic [ADDR_WIDTH-1:0]   addr1_q;
  logic                    we2_q;
  logic [ADDR_WIDTH-1:0]   addr2_q;
  logic [WORD_BYTES-1:0]   be2_q;
  logic                    pass_q;   // current write carries port-1 read data
  logic [8*WORD_BYTES-1:0] wdata_q;  // FILL pattern while writing, else 0

  logic unused_rd2;
  assign unused_rd2 = ^mem.rd_data2;

  assign mem.re1      = re1_q;
  assign mem.we1      = 1'b0;
  assign mem.addr1    = addr1_q;
  assign mem.wr_data1 = '0;
  assign mem.be1      = '0;
  assign mem.re2      = 1'b0;
  assign mem.we2      = we2_q;
  assign mem.addr2    = addr2_q;
  assign mem.be2      = be2_q;
  // Read data arrives one clock after re1 and is written in that same cycle,
  // so the copy path is a combinational pass-through rather than a register.
  assign mem.wr_data2 = pass_q ? mem.rd_data1 : wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      wr_ptr  <= '0;
      be_q    <= '0;
      re1_q   <= 1'b0;
      addr1_q <= '0;
      we2_q   <= 1'b0;
      addr2_q <= '0;
      be2_q   <= '0;
      pass_q  <= 1'b0;
      wdata_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (mode_e'(mode) == MODE_COPY) begin
              state   <= ST_RD;
              busy    <= 1'b1;
              re1_q   <= 1'b1;
              addr1_q <= src_addr;
              wr_ptr  <= dst_addr;
              be_q    <= wr_be;
              cnt     <= len - 1'b1;
            end else begin
              state   <= ST_WRF;
              busy    <= 1'b1;
              we2_q   <= 1'b1;
              addr2_q <= dst_addr;
              be2_q   <= wr_be;
              wdata_q <= fill_data;
              cnt     <= len - 1'b1;
            end
          end
        end

        // Each read issued here is written one cycle later through port 2.
        ST_RD: begin
          we2_q   <= 1'b1;
          pass_q  <= 1'b1;
          addr2_q <= wr_ptr;
          be2_q   <= be_q;
          wr_ptr  <= wr_ptr + 1'b1;
          if (cnt != '0) begin
            addr1_q <= addr1_q + 1'b1;
            cnt     <= cnt - 1'b1;
          end else begin
            re1_q   <= 1'b0;
            addr1_q <= '0;
            state   <= ST_WR_LAST;
          end
        end

        ST_WR_LAST: begin
          we2_q   <= 1'b0;
          pass_q  <= 1'b0;
          addr2_q <= '0;
          be2_q   <= '0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= ST_DONE;
        end

        ST_WRF: begin
          if (cnt != '0) begin
            addr2_q <= addr2_q + 1'b1;
            cnt     <= cnt - 1'b1;
          end else begin
            we2_q   <= 1'b0;
            addr2_q <= '0;
            be2_q   <= '0;
            wdata_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
